register_file: RTL and testbench

- Parametrised successor to the team's single 4-bit enable register: a bank of DEPTH registers, each WIDTH bits wide.
- One synchronous write port and two independent registered read ports (A and B).
- Each entry carries a "written since reset" flag.
- Used as general-purpose storage for the sprint datapath: ALU operands, accumulators and scratch.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/register_file_rdport.sv | 78 +++++++
 rtl/register_file.sv | 88 ++++++++
 tb/tb_register_file.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, helpers and types for register_file.
//   RF_DEF_WIDTH / RF_DEF_DEPTH : default bank geometry
//   RF_MAX_W                    : widest supported WIDTH (sizes rd_res_t.data)
//   addr_w(depth)               : address width, max(1, clog2(depth))
//   rd_res_t                    : read-port result {data, valid}, shared by both ports
package regfile_pkg;

  localparam int RF_DEF_WIDTH = 4;
  localparam int RF_DEF_DEPTH = 8;

  // The result struct is shared across instances of any WIDTH, so data is
  // sized for the widest supported register; unused upper bits stay zero and
  // are optimised away.
  localparam int RF_MAX_W = 64;

  function automatic int addr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic [RF_MAX_W-1:0] data;
    logic                valid;
  } rd_res_t;

endpackage

// File: rtl/register_file_rdport.sv
// register_file_rdport: one registered read port of register_file.
//   Owns the output register, hold-when-idle behaviour, range / zero-register
//   checks and, when REGFILE_BYPASS_EN is defined, write-through forwarding.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   re, raddr        : read enable and address
//   mem, flags       : storage contents and written-since-reset flags
//   wr_ok            : a legal write is happening this cycle
//   waddr, wdata     : write address/data (used only for forwarding)
//   res              : registered {data, valid}; only data[WIDTH-1:0] is live
// Optional feature: REGFILE_BYPASS_EN (write-through forwarding).
module register_file_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_DEF_WIDTH,
  parameter int DEPTH    = RF_DEF_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int ADDR_W   = addr_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        re,
  input  logic [ADDR_W-1:0]           raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            flags,
  input  logic                        wr_ok,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [WIDTH-1:0]            wdata,
  output rd_res_t                     res
);

  logic    in_range;
  logic    is_zero;
  rd_res_t nxt;

  // Extra compare bit: DEPTH itself does not fit in ADDR_W bits when it is a
  // power of two.
  assign in_range = ({1'b0, raddr} < (ADDR_W+1)'(DEPTH));
  assign is_zero  = (ZERO_REG != 0) && (raddr == '0);

  always_comb begin
    nxt = '0;
    if (is_zero) begin
      nxt.valid = 1'b1;
    end else if (in_range) begin
`ifdef REGFILE_BYPASS_EN
      // wr_ok already excludes out-of-range and zero-register writes, so an
      // address match here can only be a forwardable write.
      if (wr_ok && (waddr == raddr)) begin
        nxt.data  = RF_MAX_W'(wdata);
        nxt.valid = 1'b1;
      end else begin
        nxt.data  = RF_MAX_W'(mem[raddr]);
        nxt.valid = flags[raddr];
      end
`else
      // Read-before-write: mem/flags are the pre-edge contents.
      nxt.data  = RF_MAX_W'(mem[raddr]);
      nxt.valid = flags[raddr];
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{wr_ok, waddr, wdata};
`endif

  // Output register holds its value while re is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      res <= '0;
    end else if (re) begin
      res <= nxt;
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register bank, one write port, two registered
// read ports (A, B) with a per-entry written-since-reset flag.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   we, waddr, wdata            : write port
//   re_a, raddr_a -> rdata_a, rvalid_a : read port A, 1-cycle latency
//   re_b, raddr_b -> rdata_b, rvalid_b : read port B, 1-cycle latency
// Parameters: WIDTH (<= RF_MAX_W), DEPTH (>= 2), ZERO_REG (entry 0 reads
//   0/valid and ignores writes). ADDR_W is derived.
// Optional feature: REGFILE_BYPASS_EN enables write-through forwarding on both
//   read ports; otherwise reads of the address being written return the old
//   contents.
module register_file
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = RF_DEF_WIDTH,
  parameter  int DEPTH    = RF_DEF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            flags;
  logic [DEPTH-1:0]            wr_sel;
  logic                        wr_ok;
  rd_res_t                     res_a;
  rd_res_t                     res_b;

  // A write is legal only inside the bank and never to a hardwired entry 0.
  assign wr_ok = we
              && ({1'b0, waddr} < (ADDR_W+1)'(DEPTH))
              && !((ZERO_REG != 0) && (waddr == '0));

  // One-hot write decode, one storage slot per entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign wr_sel[i] = wr_ok && (waddr == ADDR_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        mem[i]   <= '0;
        flags[i] <= 1'b0;
      end else if (wr_sel[i]) begin
        mem[i]   <= wdata;
        flags[i] <= 1'b1;
      end
    end
  end

  register_file_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .ADDR_W(ADDR_W)
  ) u_rd_a (
    .clk(clk), .reset(reset), .re(re_a), .raddr(raddr_a),
    .mem(mem), .flags(flags), .wr_ok(wr_ok), .waddr(waddr), .wdata(wdata),
    .res(res_a)
  );

  register_file_rdport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .ADDR_W(ADDR_W)
  ) u_rd_b (
    .clk(clk), .reset(reset), .re(re_b), .raddr(raddr_b),
    .mem(mem), .flags(flags), .wr_ok(wr_ok), .waddr(waddr), .wdata(wdata),
    .res(res_b)
  );

  assign rdata_a  = res_a.data[WIDTH-1:0];
  assign rvalid_a = res_a.valid;
  assign rdata_b  = res_b.data[WIDTH-1:0];
  assign rvalid_b = res_b.valid;

  // Upper struct bits are constant zero; fold them so nothing dangles.
  logic unused_hi;
  assign unused_hi = ^{res_a.data, res_b.data};

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: drives two register_file instances with shared stimulus
//   u0: WIDTH=4, DEPTH=8, ZERO_REG=0
//   u1: WIDTH=4, DEPTH=6, ZERO_REG=1 (3-bit address, so 6 and 7 are out of range)
// and compares every output after every edge with a behavioural model built
// from plain arrays. Honours REGFILE_BYPASS_EN in its expectations.
module tb_register_file;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, we, re_a, re_b;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [3:0] wdata;
  logic [3:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic       rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;

  register_file u0 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0)
  );

  register_file #(.WIDTH(4), .DEPTH(6), .ZERO_REG(1)) u1 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mem_m [2][8];
  int flg_m [2][8];
  int exp_d [2][2];   // [instance][port A=0,B=1]
  int exp_v [2][2];

  function automatic int dep(input int k); return (k == 1) ? 6 : 8; endfunction
  function automatic bit zr(input int k);  return (k == 1);         endfunction

  function automatic bit legal_wr(input int k);
    return we && (int'(waddr) < dep(k)) && !(zr(k) && waddr == 3'd0);
  endfunction

  function automatic void model_rd(input int k, input int a, output int d, output int v);
    if (zr(k) && a == 0) begin
      d = 0; v = 1;
    end else if (a >= dep(k)) begin
      d = 0; v = 0;
`ifdef REGFILE_BYPASS_EN
    end else if (legal_wr(k) && int'(waddr) == a) begin
      d = int'(wdata); v = 1;
`endif
    end else begin
      d = mem_m[k][a]; v = flg_m[k][a];
    end
  endfunction

  task automatic model_edge();
    int d, v;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) begin mem_m[k][i] = 0; flg_m[k][i] = 0; end
        for (int p = 0; p < 2; p++) begin exp_d[k][p] = 0; exp_v[k][p] = 0; end
      end else begin
        if (re_a) begin model_rd(k, int'(raddr_a), d, v); exp_d[k][0] = d; exp_v[k][0] = v; end
        if (re_b) begin model_rd(k, int'(raddr_b), d, v); exp_d[k][1] = d; exp_v[k][1] = v; end
        if (legal_wr(k)) begin
          mem_m[k][waddr] = int'(wdata);
          flg_m[k][waddr] = 1;
        end
      end
    end
  endtask

  // One clock: update the model at the edge, then compare just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("u0.rdata_a",  32'(rdata_a0),  32'(exp_d[0][0]));
    chk("u0.rvalid_a", 32'(rvalid_a0), 32'(exp_v[0][0]));
    chk("u0.rdata_b",  32'(rdata_b0),  32'(exp_d[0][1]));
    chk("u0.rvalid_b", 32'(rvalid_b0), 32'(exp_v[0][1]));
    chk("u1.rdata_a",  32'(rdata_a1),  32'(exp_d[1][0]));
    chk("u1.rvalid_a", 32'(rvalid_a1), 32'(exp_v[1][0]));
    chk("u1.rdata_b",  32'(rdata_b1),  32'(exp_d[1][1]));
    chk("u1.rvalid_b", 32'(rvalid_b1), 32'(exp_v[1][1]));
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    waddr = '0; raddr_a = '0; raddr_b = '0; wdata = '0;

    // reset state
    step();
    chk("rst.rdata_a", 32'(rdata_a0), 32'h0);
    chk("rst.rvalid_b", 32'(rvalid_b1), 32'h0);

    // read every address after reset: all 0/0 (u1 entry 0 reads 0/1)
    idle();
    for (int i = 0; i < 8; i++) begin
      re_a = 1'b1; re_b = 1'b1; raddr_a = 3'(i); raddr_b = 3'(7 - i);
      step();
    end

    // write / readback
    idle(); we = 1'b1; waddr = 3'd3; wdata = 4'hA; step();
    waddr = 3'd7; wdata = 4'h5; step();
    idle(); re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd7; step();
    chk("wr.a3", 32'(rdata_a0), 32'hA);
    chk("wr.b7", 32'(rdata_b0), 32'h5);
    chk("wr.b7v", 32'(rvalid_b0), 32'h1);
    chk("wr.u1oob", 32'(rvalid_b1), 32'h0);
    raddr_a = 3'd2; raddr_b = 3'd2; step();
    chk("wr.a2v", 32'(rvalid_a0), 32'h0);

    // same-cycle write/read collision
    idle(); we = 1'b1; waddr = 3'd4; wdata = 4'h1; step();
    wdata = 4'hC; re_a = 1'b1; raddr_a = 3'd4; step();
`ifdef REGFILE_BYPASS_EN
    chk("coll", 32'(rdata_a0), 32'hC);
`else
    chk("coll", 32'(rdata_a0), 32'h1);
`endif
    we = 1'b0; step();
    chk("coll.next", 32'(rdata_a0), 32'hC);

    // hold while re is low, then out-of-range read on u1
    idle(); we = 1'b1; waddr = 3'd5; wdata = 4'h6; step();
    idle(); re_a = 1'b1; raddr_a = 3'd5; step();
    chk("hold.rd", 32'(rdata_a1), 32'h6);
    re_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; waddr = 3'd5; wdata = 4'($urandom); raddr_a = 3'($urandom);
      step();
      chk("hold.a1", 32'(rdata_a1), 32'h6);
    end
    idle(); re_a = 1'b1; raddr_a = 3'd6; step();
    chk("oob.d", 32'(rdata_a1), 32'h0);
    chk("oob.v", 32'(rvalid_a1), 32'h0);
    idle(); we = 1'b1; waddr = 3'd7; wdata = 4'hF; step();
    idle();
    for (int i = 0; i < 8; i++) begin
      re_a = 1'b1; re_b = 1'b1; raddr_a = 3'(i); raddr_b = 3'(i);
      step();
    end

    // zero register
    idle(); we = 1'b1; waddr = 3'd0; wdata = 4'hF; step();
    idle(); re_a = 1'b1; raddr_a = 3'd0; step();
    chk("zr.d", 32'(rdata_a1), 32'h0);
    chk("zr.v", 32'(rvalid_a1), 32'h1);
    chk("zr.u0", 32'(rdata_a0), 32'hF);

    // reset mid-stream
    idle(); reset = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 4'h9;
    re_b = 1'b1; raddr_b = 3'd2; step();
    chk("rmid.d", 32'(rdata_b0), 32'h0);
    chk("rmid.v", 32'(rvalid_b0), 32'h0);
    idle(); step();
    re_b = 1'b1; raddr_b = 3'd2; step();
    chk("rmid.rd", 32'(rdata_b0), 32'h0);
    chk("rmid.rv", 32'(rvalid_b0), 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 99) == 0);
      we      = 1'($urandom);
      waddr   = 3'($urandom);
      wdata   = 4'($urandom);
      re_a    = 1'($urandom);
      re_b    = 1'($urandom);
      raddr_a = 3'($urandom);
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom);
      if ($urandom_range(0, 3) == 0) raddr_a = waddr;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
